// File: rtl/ram_to_stream.sv
// Reads a requested number of fixed-size blocks from one RAM bank over AXI4 and
// forwards the read data unbuffered as an AXI-Stream with TLAST per block.
module ram_to_stream #(
  parameter int          DW              = 512,
  parameter int          BLOCK_BEATS     = 32,
  parameter logic [63:0] BASE_ADDR       = 64'h0,
  parameter int unsigned MAX_BLOCKS      = 65536,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [31:0]     block_count,
  output logic            busy,
  output logic            done,
  output logic [31:0]     blocks_read,
  output logic            read_error,
  output logic [63:0]     M_AXI_ARADDR,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic [3:0]      M_AXI_ARID,
  output logic            M_AXI_ARLOCK,
  output logic [3:0]      M_AXI_ARCACHE,
  output logic [3:0]      M_AXI_ARQOS,
  output logic [2:0]      M_AXI_ARPROT,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY,
  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic [3:0]      M_AXI_AWID,
  output logic            M_AXI_AWLOCK,
  output logic [3:0]      M_AXI_AWCACHE,
  output logic [3:0]      M_AXI_AWQOS,
  output logic [2:0]      M_AXI_AWPROT,
  output logic            M_AXI_AWVALID,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_BREADY,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic            AXIS_OUT_TVALID,
  output logic            AXIS_OUT_TLAST,
  input  logic            AXIS_OUT_TREADY
);

  localparam logic [63:0] BLOCK_BYTES = 64'(BLOCK_BEATS * (DW / 8));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t      state;
  logic [31:0] target;
  logic [31:0] ar_issued;
  logic [4:0]  outstanding;
  logic [4:0]  outstanding_next;
  logic [31:0] blocks_next;
  logic [31:0] req_target;
  logic        ar_hs;
  logic        r_hs;
  logic        rlast_hs;

  assign req_target = (block_count > 32'(MAX_BLOCKS)) ? 32'(MAX_BLOCKS) : block_count;

  assign ar_hs    = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs     = M_AXI_RVALID & M_AXI_RREADY;
  assign rlast_hs = r_hs & M_AXI_RLAST;

  // Post-edge counter values let completion be seen in the same cycle as the final RLAST.
  assign outstanding_next = outstanding + {4'd0, ar_hs} - {4'd0, rlast_hs};
  assign blocks_next      = blocks_read + 32'(rlast_hs);

  // Zero-latency R-to-AXIS pass-through, gated by busy.
  assign AXIS_OUT_TDATA  = M_AXI_RDATA;
  assign AXIS_OUT_TLAST  = M_AXI_RLAST;
  assign AXIS_OUT_TVALID = busy & M_AXI_RVALID;
  assign M_AXI_RREADY    = busy & AXIS_OUT_TREADY;

  assign M_AXI_ARLEN   = 8'(BLOCK_BEATS - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
  assign M_AXI_ARBURST = 2'd1;
  assign M_AXI_ARID    = 4'd0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;

  assign M_AXI_AWADDR  = 64'd0;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'd0;
  assign M_AXI_AWBURST = 2'd0;
  assign M_AXI_AWID    = 4'd0;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_WDATA   = '0;
  assign M_AXI_WSTRB   = '0;
  assign M_AXI_WLAST   = 1'b0;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_BREADY  = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= BASE_ADDR;
      target        <= 32'd0;
      ar_issued     <= 32'd0;
      outstanding   <= 5'd0;
      blocks_read   <= 32'd0;
      read_error    <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding_next;
      if (rlast_hs)
        blocks_read <= blocks_next;
      if (r_hs && (M_AXI_RRESP != 2'd0))
        read_error <= 1'b1;
      if (ar_hs) begin
        M_AXI_ARVALID <= 1'b0;
        M_AXI_ARADDR  <= M_AXI_ARADDR + BLOCK_BYTES;
        ar_issued     <= ar_issued + 32'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            target       <= req_target;
            blocks_read  <= 32'd0;
            read_error   <= 1'b0;
            M_AXI_ARADDR <= BASE_ADDR;
            ar_issued    <= 32'd0;
            busy         <= 1'b1;
            state        <= (req_target == 32'd0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          // ARVALID drops after each handshake so the in-flight limit is re-checked.
          if (ar_hs) begin
            if (ar_issued + 32'd1 == target)
              state <= DRAIN;
          end else if (!M_AXI_ARVALID && (ar_issued < target) &&
                       (outstanding < 5'(MAX_OUTSTANDING))) begin
            M_AXI_ARVALID <= 1'b1;
          end
        end
        DRAIN: begin
          if ((blocks_next == target) && (outstanding_next == 5'd0)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_to_stream.sv
// Bench for ram_to_stream: AXI4 read slave with a memory model, random stalls,
// and an expected-stream queue built from the requested block count.
`timescale 1ns/1ps
module tb_ram_to_stream;
  localparam int          DW   = 512;
  localparam int          BB   = 32;
  localparam int          MAXB = 12;
  localparam int          MAXO = 4;
  localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

  logic            clk;
  logic            resetn;
  logic            start;
  logic [31:0]     block_count;
  logic            busy, done, read_error;
  logic [31:0]     blocks_read;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize, arprot;
  logic [1:0]      arburst;
  logic [3:0]      arid, arcache, arqos;
  logic            arlock, arvalid, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize, awprot;
  logic [1:0]      awburst;
  logic [3:0]      awid, awcache, awqos;
  logic            awlock, awvalid;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, bready;
  logic [DW-1:0]   tdata;
  logic            tvalid, tlast, tready;

  ram_to_stream #(
    .DW(DW), .BLOCK_BEATS(BB), .BASE_ADDR(BASE), .MAX_BLOCKS(MAXB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .block_count(block_count),
    .busy(busy), .done(done), .blocks_read(blocks_read), .read_error(read_error),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARID(arid), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWID(awid), .M_AXI_AWLOCK(awlock),
    .M_AXI_AWCACHE(awcache), .M_AXI_AWQOS(awqos), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_BREADY(bready),
    .AXIS_OUT_TDATA(tdata), .AXIS_OUT_TVALID(tvalid), .AXIS_OUT_TLAST(tlast),
    .AXIS_OUT_TREADY(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    int          rdy;
  } ar_t;

  int n_cmp = 0;
  int n_err = 0;

  // Slave/scoreboard state and per-run configuration.
  ar_t             ar_q[$];
  logic [DW:0]     exp_q[$];
  int              r_beat = 0, burst_no = 0, ar_cnt = 0, out_m = 0, max_out = 0, viol = 0;
  int              beats = 0, arv_seen = 0, done_cnt = 0, done_cyc = 0, last_rl = 0;
  int              r_delay = 0, start_cyc = 0, tgt = 0;
  bit              ar_rand = 0, tr_rand = 0, r_stall = 0, err_en = 0;
  bit              r_hold = 0, arv_pend = 0;
  logic [63:0]     pend_addr = '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem(input logic [63:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 64; i++)
      d[i*64 +: 64] = a ^ (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));
    return d;
  endfunction

  // Slave drives at negedge; #1 later the upcoming handshakes are already determined.
  always @(negedge clk) begin
    if (!resetn) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; rdata = '0;
      tready = 1'b0; r_hold = 0; arv_pend = 0; r_beat = 0;
      ar_q.delete();
    end else begin
      arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      tready  = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!r_hold) begin
        if (ar_q.size() > 0 && cyc >= ar_q[0].rdy && (!r_stall || $urandom_range(0, 1) == 1)) begin
          rvalid = 1'b1;
          rdata  = mem(ar_q[0].addr + 64'(r_beat * (DW / 8)));
          rlast  = (r_beat == BB - 1);
          rresp  = (err_en && burst_no == 1 && r_beat == 5) ? 2'd2 : 2'd0;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        end
      end
      #1;
      check("rready", rready, tready && busy);
      check("tvalid", tvalid, rvalid && busy);
      if (arvalid) arv_seen++;
      if (arv_pend) check("ar_hold", {arvalid, araddr}, {1'b1, pend_addr});
      arv_pend  = arvalid && !arready;
      pend_addr = araddr;
      if (arvalid && out_m >= MAXO) viol++;
      if (arvalid && arready) begin
        ar_t t;
        check("araddr", araddr, BASE + 64'(ar_cnt) * 64'h800);
        check("ar_fields", {arlen, arsize, arburst}, {8'd31, 3'd6, 2'd1});
        t.addr = araddr;
        t.rdy  = cyc + r_delay;
        ar_q.push_back(t);
        ar_cnt++;
        out_m++;
        if (out_m > max_out) max_out = out_m;
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("tdata", tdata, e[DW-1:0]);
          check("tlast", tlast, e[DW]);
        end
        beats++;
        if (rlast) begin
          if (ar_q.size() > 0) void'(ar_q.pop_front());
          r_beat = 0; burst_no++; out_m--; last_rl = cyc;
        end else begin
          r_beat++;
        end
        r_hold = 0;
      end else begin
        r_hold = rvalid;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_run(input int n);
    tgt = (n > MAXB) ? MAXB : n;
    exp_q.delete();
    for (int b = 0; b < tgt; b++)
      for (int k = 0; k < BB; k++)
        exp_q.push_back({(k == BB - 1), mem(BASE + 64'((b * BB + k) * (DW / 8)))});
    ar_cnt = 0; burst_no = 0; beats = 0; max_out = 0; viol = 0; arv_seen = 0;
    out_m = 0; r_beat = 0;
    @(negedge clk);
    start = 1'b1;
    block_count = 32'(n);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("rerr_cleared", read_error, 0);
  endtask

  task automatic finish_run(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    if (tgt == 0) check("done_lat0", done_cyc, start_cyc + 2);
    else          check("done_lat", done_cyc, last_rl + 1);
    repeat (5) @(negedge clk);
    #2;
    check("done_single", done_cnt, d0 + 1);
    check("busy_end", busy, 0);
    check("blocks_read", blocks_read, tgt);
    check("ar_count", ar_cnt, tgt);
    check("beats", beats, tgt * BB);
    check("exp_left", exp_q.size(), 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; block_count = 32'd0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, BASE);
    check("rst_blocks", blocks_read, 0);
    check("rst_rerr", read_error, 0);
    check("tie_ctl", {awvalid, wvalid, bready}, 3'b001);
    check("tie_aw", {awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot}, 0);
    check("tie_w", {wdata, wstrb, wlast}, 0);
    check("tie_ar", {arid, arlock, arcache, arqos, arprot}, 0);
    resetn = 1'b1;

    // Ideal slave, three blocks.
    start_run(3);
    finish_run(2000);
    check("rerr_clean", read_error, 0);

    // Empty request.
    start_run(0);
    finish_run(50);
    check("no_arvalid", arv_seen, 0);

    // Long read latency exercises the in-flight limit.
    r_delay = 50;
    start_run(10);
    finish_run(4000);
    check("max_outstanding", max_out, MAXO);
    check("arvalid_at_limit", viol, 0);

    // Random ARREADY, RVALID gaps and TREADY.
    r_delay = 3; ar_rand = 1; tr_rand = 1; r_stall = 1;
    start_run(6);
    finish_run(8000);
    check("rand_limit", viol, 0);

    // Error response on block 1 beat 5.
    r_delay = 0; ar_rand = 0; tr_rand = 0; r_stall = 0; err_en = 1;
    start_run(3);
    finish_run(2000);
    check("rerr_set", read_error, 1);
    err_en = 0;
    start_run(1);
    finish_run(500);
    check("rerr_next", read_error, 0);

    // Reset in the middle of block 2.
    start_run(5);
    for (int i = 0; i < 2000; i++) begin
      if (burst_no == 2 && r_beat >= 10) break;
      @(negedge clk);
    end
    check("reached_block2", burst_no, 2);
    @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_arvalid", arvalid, 0);
    check("mid_araddr", araddr, BASE);
    check("mid_blocks", blocks_read, 0);
    check("mid_rerr", read_error, 0);
    check("mid_tvalid", tvalid, 0);
    check("mid_rready", rready, 0);
    repeat (2) @(negedge clk);
    #3;
    resetn = 1'b1;
    start_run(2);
    finish_run(1000);

    // Oversized request is clamped to the bank capacity.
    start_run(MAXB + 5);
    finish_run(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t required completion", $time);
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/ram_to_stream.md
Name: ram_to_stream

Overview:
- Read-back stage directly downstream of the capture-to-RAM writer.
- Once a capture is complete, it reads a requested number of fixed-size RAM blocks from one RAM bank over the AXI4 read channels.
- It emits the data in address order as an AXI-Stream, with TLAST marking the end of each block.
- The AXI4 write channels are tied off.

Parameters:
- DW, 512, data width in bits, both AXI4 and AXIS.
- BLOCK_BEATS, 32, beats per RAM block; ARLEN = BLOCK_BEATS-1; legal range 1..256.
- BASE_ADDR, 64'h0, byte address of block 0 of this bank.
- MAX_BLOCKS, 65536, bank capacity in blocks.
- MAX_OUTSTANDING, 4, maximum AR bursts in flight; range 1..15.

Ports:
- clk, in, 1: sole clock.
- resetn, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that begins a read-back; ignored while busy.
- block_count, in, 32: blocks to read; sampled on an accepted start.
- busy, out, 1: high from the accepted start until done.
- done, out, 1: one-cycle pulse when the read-back completes.
- blocks_read, out, 32: count of blocks fully delivered on AXIS in the current or last run.
- read_error, out, 1: sticky; set by any RRESP != 0; cleared by the next accepted start.
- M_AXI_ARADDR, out, 64: read address.
- M_AXI_ARLEN, out, 8: BLOCK_BEATS-1.
- M_AXI_ARSIZE, out, 3: $clog2(DW/8).
- M_AXI_ARBURST, out, 2: 1 (INCR).
- M_AXI_ARID, out, 4: 0.
- M_AXI_ARLOCK, out, 1: 0.
- M_AXI_ARCACHE, out, 4: 0.
- M_AXI_ARQOS, out, 4: 0.
- M_AXI_ARPROT, out, 3: 0.
- M_AXI_ARVALID, out, 1: read request valid.
- M_AXI_ARREADY, in, 1: slave accepts the read request.
- M_AXI_RDATA, in, DW: read data.
- M_AXI_RRESP, in, 2: read response.
- M_AXI_RLAST, in, 1: last beat of a burst.
- M_AXI_RVALID, in, 1: read data valid.
- M_AXI_RREADY, out, 1: master accepts read data.
- AW/W/B channels, out: AWVALID=0, WVALID=0, BREADY=1, all other AW/W outputs 0.
- AXIS_OUT_TDATA, out, DW: output stream data.
- AXIS_OUT_TVALID, out, 1: output stream valid.
- AXIS_OUT_TLAST, out, 1: last beat of a block.
- AXIS_OUT_TREADY, in, 1: downstream accepts a beat.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; busy=0, done=0, ARVALID=0, blocks_read=0, read_error=0; ARADDR=BASE_ADDR; internal counters=0.
  - In-flight AXI bursts are abandoned. The system must reset the slave at the same time.
- Latched request length: target = min(block_count, MAX_BLOCKS), 32-bit compare.
- R-to-AXIS path is pure pass-through with zero latency:
  - TDATA=RDATA, TLAST=RLAST, TVALID=RVALID while busy.
  - RREADY = AXIS_OUT_TREADY while busy; RREADY=0 in IDLE.
  - No internal buffer. The downstream must not make TREADY depend on TVALID combinationally in a loop.
- ARVALID is registered. Once raised, it and ARADDR hold stable until ARREADY.
- Counters:
  - ar_issued increments on each AR handshake.
  - ARADDR advances by BLOCK_BEATS*DW/8 on each AR handshake; 64-bit, no wrap check needed because target <= MAX_BLOCKS.
  - outstanding increments on AR handshake and decrements on an R handshake with RLAST. Both in the same cycle leave it unchanged.
  - blocks_read increments on an R handshake with RLAST.
- State machine:
  - IDLE: on start, latch target, clear blocks_read and read_error, ARADDR=BASE_ADDR, ar_issued=0, busy=1.
    - If target==0, go to FINISH; otherwise go to ISSUE.
  - ISSUE: raise ARVALID when ar_issued<target and outstanding<MAX_OUTSTANDING.
    - An AR handshake in the same cycle as an RLAST decrement still counts correctly.
    - After the handshake that makes ar_issued==target, go to DRAIN.
  - DRAIN: no new AR. When blocks_read==target and outstanding==0, go to FINISH.
  - FINISH: pulse done=1 for one cycle, busy=0, return to IDLE.
    - done occurs the cycle after the final RLAST handshake.
    - For target==0, done occurs 2 cycles after start.
- read_error: set on any R handshake with RRESP!=0. The data is still forwarded and the run continues to completion.
- start while busy: ignored, no effect on any counter.
- Stall behaviour: with TREADY held low, RREADY=0 and no beats are lost.
  - AR issue continues only up to MAX_OUTSTANDING bursts in flight.

Test Plan:
- Reset, then start with block_count=3, BLOCK_BEATS=32, DW=512, TREADY=1, ideal slave -> ARADDR sequence BASE, BASE+0x800, BASE+0x1000; 96 AXIS beats in order; TLAST on beats 31, 63 and 95; blocks_read=3; single done pulse; busy=0.
- block_count=0 -> no ARVALID ever; done pulses 2 cycles after start; blocks_read=0.
- block_count=10 with a slave that delays R by 50 cycles -> outstanding never exceeds 4; ARVALID drops whenever outstanding==4; all 320 beats delivered.
- Random TREADY (50%) with an RVALID-stalling slave -> AXIS data matches the memory model beat-for-beat; no duplication or loss; ARVALID/ARADDR stable until ARREADY.
- Slave returns RRESP=2 on block 1, beat 5 -> read_error=1 and stays set; run completes with blocks_read=3; next start clears read_error.
- Assert resetn low in the middle of block 2, then release -> all outputs at reset values immediately; a new start with block_count=2 completes normally from BASE_ADDR; block_count=MAX_BLOCKS+5 is clamped to MAX_BLOCKS bursts.
